// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcodes and controller states shared by the serial ALU files.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [2:0] ALU_AND    = 3'b100;
    localparam logic [2:0] ALU_OR     = 3'b101;
    localparam logic [2:0] ALU_XOR    = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_slice.sv
`default_nettype none
// ============================================================================
// Module   : alu_slice
// Brief    : One-bit ALU slice; subtraction inverts B so the caller seeds cin=1.
// Revision : 1.0
// ============================================================================
module alu_slice
    import alu_pkg::*;
(
    output logic       out_o,
    output logic       co_o,
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic [2:0] sel_i
);

    logic w_b_eff;

    always_comb begin
        w_b_eff = (sel_i == ALU_SUB) ? ~b_i : b_i;
        out_o   = 1'b0;
        co_o    = 1'b0;
        case (sel_i)
            ALU_PASS_B: out_o = b_i;
            ALU_ADD, ALU_SUB: begin
                out_o = a_i ^ w_b_eff ^ cin_i;
                co_o  = (a_i & w_b_eff) | (cin_i & (a_i ^ w_b_eff));
            end
            ALU_AND: out_o = a_i & b_i;
            ALU_OR:  out_o = a_i | b_i;
            ALU_XOR: out_o = a_i ^ b_i;
            default: out_o = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : serial_alu_seq
// Brief    : Bit-serial ALU controller, LSB first, one slice bit per clock.
// Revision : 1.0
// ============================================================================
module serial_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       sel_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             negative_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             carry_o
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_res;
    logic [2:0]       r_op;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_out;
    logic             w_co;
    logic [WIDTH-1:0] w_res_full;
    logic             w_arith;

    alu_slice u_slice (
        .out_o (w_out),
        .co_o  (w_co),
        .a_i   (r_a[0]),
        .b_i   (r_b[0]),
        .cin_i (r_carry),
        .sel_i (r_op)
    );

    // Only WIDTH-1 earlier bits are stored; the MSB comes straight from the slice.
    assign w_res_full = {w_out, r_res};
    assign w_arith    = (r_op == ALU_ADD) || (r_op == ALU_SUB);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_op       <= ALU_PASS_B;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            ready_o    <= 1'b1;
            done_o     <= 1'b0;
            result_o   <= '0;
            negative_o <= 1'b0;
            zero_o     <= 1'b0;
            overflow_o <= 1'b0;
            carry_o    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        r_a     <= a_i;
                        r_b     <= b_i;
                        r_op    <= sel_i;
                        r_carry <= (sel_i == ALU_SUB);
                        r_cnt   <= '0;
                        ready_o <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_res_full[WIDTH-1:1];
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        // r_carry here is still the carry into the MSB.
                        result_o   <= w_res_full;
                        negative_o <= w_res_full[WIDTH-1];
                        zero_o     <= ~|w_res_full;
                        carry_o    <= w_arith & w_co;
                        overflow_o <= w_arith & (r_carry ^ w_co);
                        done_o     <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    done_o  <= 1'b0;
                    ready_o <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    done_o  <= 1'b0;
                    ready_o <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
